// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the PLL reset sequencer and its surroundings.
// The sequencer sits on the slave side: it consumes the PLL lock indication and
// the restart request, and presents the PLL reset, downstream reset and status.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_error;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  sys_rst_n,
        input  pll_error,
        input  state,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output sys_rst_n,
        output pll_error,
        output state,
        output lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Pixel-clock PLL reset sequencer.
// Holds the PLL in reset for a fixed time, waits (with timeout) for lock,
// qualifies lock over a stability window and only then releases the downstream
// video reset. Lock loss while running re-sequences automatically; repeated
// lock timeouts park the block in FAILED until an explicit restart pulse.
// All outputs are registered and decoded from the next state so they move on
// the same edge as the state code.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 32,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 17
) (
    input  logic                    clk,
    input  logic                    nrst,
    pll_reset_sequencer_if.slave    bus
);

    // Retry counter only ever needs to reach MAX_RETRIES.
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAILED    = 3'd4
    } state_t;

    // Lock synchronizer stages
    logic lock_meta;
    logic lock_s;

    // Sequencer state
    state_t             state_q;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_nxt;
    logic [RETRY_W-1:0] retry_inc;
    logic [7:0]         loss_q;
    logic [7:0]         loss_nxt;

    // Registered outputs
    logic pll_rst_q;
    logic sys_rst_n_q;
    logic pll_error_q;

    // Lock-loss counter saturates instead of wrapping so a long-running
    // system never reports a misleadingly small number.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // PLL is held in reset while sequencing a fresh attempt and while parked.
    function automatic logic pll_rst_of(input state_t s);
        return (s == ST_RESET_PLL) || (s == ST_FAILED);
    endfunction

    // Downstream logic only leaves reset once lock has been qualified.
    function automatic logic sys_rst_n_of(input state_t s);
        return (s == ST_RUN);
    endfunction

    function automatic logic pll_error_of(input state_t s);
        return (s == ST_FAILED);
    endfunction

    assign retry_inc = retry_q + RETRY_W'(1);

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, retry, lock-loss and counter decisions.
    always_comb begin
        state_nxt = state_q;
        retry_nxt = retry_q;
        loss_nxt  = loss_q;

        if (bus.restart) begin
            // Restart overrides everything, including an in-progress reset.
            state_nxt = ST_RESET_PLL;
            retry_nxt = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock takes precedence over a coincident timeout.
                    if (lock_s) begin
                        state_nxt = ST_STABILIZE;
                    end else if (cnt_q == LOCK_LAST) begin
                        retry_nxt = retry_inc;
                        state_nxt = (retry_inc == RETRY_LIMIT) ? ST_FAILED
                                                               : ST_RESET_PLL;
                    end
                end
                ST_STABILIZE: begin
                    // A glitch sends us back to waiting without using a retry.
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                        retry_nxt = '0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_RESET_PLL;
                        loss_nxt  = sat_inc8(loss_q);
                    end
                end
                ST_FAILED: begin
                    state_nxt = ST_FAILED;
                end
                default: begin
                    state_nxt = ST_RESET_PLL;
                end
            endcase
        end

        // Counter measures time spent in the current state; restart also
        // clears it so a restart inside RESET_PLL begins a full reset period.
        if (bus.restart || (state_nxt != state_q)) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    // Sequencer registers with outputs decoded from the next state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_error_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            retry_q     <= retry_nxt;
            loss_q      <= loss_nxt;
            pll_rst_q   <= pll_rst_of(state_nxt);
            sys_rst_n_q <= sys_rst_n_of(state_nxt);
            pll_error_q <= pll_error_of(state_nxt);
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.pll_error     = pll_error_q;
    assign bus.state         = state_q;
    assign bus.lock_loss_cnt = loss_q;

endmodule
